// File: rtl/fifo_arb_2x1_if.sv
// Handshake bundle between two show-ahead FIFOs, the 2:1 arbiter and its downstream sink.
// The master modport is the arbiter's view; the slave modport is the FIFO/sink side.
interface fifo_arb_2x1_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  empty_0;
   logic                  empty_1;
   logic [DATA_WIDTH-1:0] data_in0;
   logic [DATA_WIDTH-1:0] data_in1;
   logic                  almost_full;
   logic                  pop_0;
   logic                  pop_1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic [1:0]            grant;

   modport master (
      input  empty_0, empty_1, data_in0, data_in1, almost_full,
      output pop_0, pop_1, data_out, valid_out, grant
   );

   modport slave (
      output empty_0, empty_1, data_in0, data_in1, almost_full,
      input  pop_0, pop_1, data_out, valid_out, grant
   );
endinterface

// File: rtl/fifo_arb_2x1.sv
// Two-FIFO to one-sink arbiter: round-robin with bounded bursts, or strict FIFO0
// priority when ARB_STRICT_PRIO_EN is defined. Pops are combinational, data_out is registered.
module fifo_arb_2x1 #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic clk,
   input  logic reset,
   fifo_arb_2x1_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            burst_cnt;
   logic [3:0]            burst_nxt;
   logic                  last_served;
   logic                  pop0;
   logic                  pop1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  vld_p1;

   // reset gates the strobes so nothing is consumed while it is low
   assign pop0 = reset & (state == GRANT0) & ~bus.empty_0 & ~bus.almost_full;
   assign pop1 = reset & (state == GRANT1) & ~bus.empty_1 & ~bus.almost_full;

   assign bus.pop_0     = pop0;
   assign bus.pop_1     = pop1;
   assign bus.grant     = state;
   assign bus.data_out  = data_p1;
   assign bus.valid_out = vld_p1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         burst_cnt   <= 4'd0;
         last_served <= 1'b1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         if (pop0)
            last_served <= 1'b0;
         else if (pop1)
            last_served <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      case (state)
         IDLE: begin
`ifdef ARB_STRICT_PRIO_EN
            if (!bus.empty_0)
               state_nxt = GRANT0;
            else if (!bus.empty_1)
               state_nxt = GRANT1;
`else
            if (!bus.empty_0 && !bus.empty_1)
               state_nxt = last_served ? GRANT0 : GRANT1;
            else if (!bus.empty_0)
               state_nxt = GRANT0;
            else if (!bus.empty_1)
               state_nxt = GRANT1;
`endif
         end
         GRANT0: begin
            if (!bus.almost_full) begin
               if (bus.empty_0)
                  state_nxt = bus.empty_1 ? IDLE : GRANT1;
`ifdef ARB_STRICT_PRIO_EN
               else
                  burst_nxt = burst_cnt + 4'd1;
`else
               else if (burst_cnt == BURST_LAST) begin
                  burst_nxt = 4'd0;
                  if (!bus.empty_1)
                     state_nxt = GRANT1;
               end else
                  burst_nxt = burst_cnt + 4'd1;
`endif
            end
         end
         GRANT1: begin
            if (!bus.almost_full) begin
               if (bus.empty_1)
                  state_nxt = bus.empty_0 ? IDLE : GRANT0;
`ifdef ARB_STRICT_PRIO_EN
               else if (!bus.empty_0)
                  state_nxt = GRANT0;
`endif
               else if (burst_cnt == BURST_LAST) begin
                  burst_nxt = 4'd0;
                  if (!bus.empty_0)
                     state_nxt = GRANT0;
               end else
                  burst_nxt = burst_cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state)
         burst_nxt = 4'd0;
   end

   // stage p1: forwarded word, one cycle after the pop strobe
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= pop0 | pop1;
         if (pop0)
            data_p1 <= bus.data_in0;
         else if (pop1)
            data_p1 <= bus.data_in1;
      end
   end

endmodule

// File: tb/tb_fifo_arb_2x1.sv
// Directed bench for fifo_arb_2x1: queue-backed FIFO models and hand-computed cycle-by-cycle expectations.
module tb_fifo_arb_2x1;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] prev;

   fifo_arb_2x1_if #(.DATA_WIDTH(8)) bus();

   fifo_arb_2x1 #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic settle();
      bus.empty_0  = (q0.size() == 0);
      bus.empty_1  = (q1.size() == 0);
      bus.data_in0 = (q0.size() != 0) ? q0[0] : 8'h00;
      bus.data_in1 = (q1.size() != 0) ? q1[0] : 8'h00;
      #1;
   endtask

   task automatic advance();
      logic a0;
      logic a1;
      logic [7:0] tmp;
      a0 = bus.pop_0;
      a1 = bus.pop_1;
      @(posedge clk);
      #1;
      if (a0) tmp = q0.pop_front();
      if (a1) tmp = q1.pop_front();
   endtask

   task automatic expect_arb(input string tag, input logic [1:0] g, input logic p0, input logic p1);
      check({tag, "_grant"}, 8'(bus.grant), 8'(g));
      check({tag, "_pop0"}, 8'(bus.pop_0), 8'(p0));
      check({tag, "_pop1"}, 8'(bus.pop_1), 8'(p1));
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
      check({tag, "_valid"}, 8'(bus.valid_out), 8'(v));
      if (v) check({tag, "_data"}, bus.data_out, d);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      reset           = 1'b0;
      bus.almost_full = 1'b0;
      prev            = 8'h00;

`ifndef ARB_STRICT_PRIO_EN
      // both FIFOs full of 8 words through reset, then bursts of 4 alternating
      for (int i = 0; i < 8; i++) begin
         q0.push_back(8'(8'h10 + i));
         q1.push_back(8'(8'h80 + i));
      end
      for (int i = 0; i < 2; i++) begin
         settle();
         check("rst_pop0", 8'(bus.pop_0), 8'h00);
         check("rst_pop1", 8'(bus.pop_1), 8'h00);
         advance();
      end
      reset = 1'b1;
      settle();
      check("rst_data", bus.data_out, 8'h00);
      expect_out("rst", 1'b0, 8'h00);
      expect_arb("t1_idle", 2'b00, 1'b0, 1'b0);
      advance();
      for (int k = 0; k < 16; k++) begin
         int b;
         int j;
         b = k / 4;
         j = k % 4;
         settle();
         if (b % 2 == 0) expect_arb("t1_b0", 2'b01, 1'b1, 1'b0);
         else            expect_arb("t1_b1", 2'b10, 1'b0, 1'b1);
         expect_out("t1", k != 0, prev);
         prev = 8'(((b % 2 == 0) ? 'h10 : 'h80) + (b / 2) * 4 + j);
         advance();
      end
      settle();
      expect_arb("t1_tail", 2'b10, 1'b0, 1'b0);
      expect_out("t1_tail", 1'b1, 8'h87);
      advance();
      settle();
      expect_arb("t1_end", 2'b00, 1'b0, 1'b0);
      expect_out("t1_end", 1'b0, 8'h00);
      check("t1_hold", bus.data_out, 8'h87);
      advance();

      // only FIFO1 holds 10 words: counter wraps without switching
      for (int i = 0; i < 10; i++) q1.push_back(8'(8'hA0 + i));
      settle();
      expect_arb("t2_idle", 2'b00, 1'b0, 1'b0);
      advance();
      for (int k = 0; k < 10; k++) begin
         settle();
         expect_arb("t2_run", 2'b10, 1'b0, 1'b1);
         expect_out("t2", k != 0, prev);
         prev = 8'(8'hA0 + k);
         advance();
      end
      settle();
      expect_arb("t2_tail", 2'b10, 1'b0, 1'b0);
      expect_out("t2_tail", 1'b1, 8'hA9);
      advance();
      settle();
      expect_arb("t2_end", 2'b00, 1'b0, 1'b0);
      expect_out("t2_end", 1'b0, 8'h00);
      advance();

      // backpressure mid-burst
      for (int i = 0; i < 8; i++) begin
         q0.push_back(8'(8'h20 + i));
         q1.push_back(8'(8'hC0 + i));
      end
      settle();
      expect_arb("t3_idle", 2'b00, 1'b0, 1'b0);
      advance();
      settle();
      expect_arb("t3_p0", 2'b01, 1'b1, 1'b0);
      expect_out("t3_p0", 1'b0, 8'h00);
      advance();
      settle();
      expect_arb("t3_p1", 2'b01, 1'b1, 1'b0);
      expect_out("t3_p1", 1'b1, 8'h20);
      advance();
      bus.almost_full = 1'b1;
      for (int s = 0; s < 5; s++) begin
         settle();
         expect_arb("t3_stall", 2'b01, 1'b0, 1'b0);
         expect_out("t3_stall", s == 0, 8'h21);
         advance();
      end
      bus.almost_full = 1'b0;
      settle();
      expect_arb("t3_rel0", 2'b01, 1'b1, 1'b0);
      expect_out("t3_rel0", 1'b0, 8'h00);
      advance();
      settle();
      expect_arb("t3_rel1", 2'b01, 1'b1, 1'b0);
      expect_out("t3_rel1", 1'b1, 8'h22);
      advance();
      settle();
      expect_arb("t3_sw", 2'b10, 1'b0, 1'b1);
      expect_out("t3_sw", 1'b1, 8'h23);
      advance();
      settle();
      expect_arb("t4_g1", 2'b10, 1'b0, 1'b1);
      expect_out("t4_g1", 1'b1, 8'hC0);
      advance();

      // one-cycle reset inside the FIFO1 burst
      reset = 1'b0;
      settle();
      expect_arb("t4_rst", 2'b10, 1'b0, 1'b0);
      advance();
      reset = 1'b1;
      settle();
      expect_arb("t4_after", 2'b00, 1'b0, 1'b0);
      expect_out("t4_after", 1'b0, 8'h00);
      check("t4_data", bus.data_out, 8'h00);
      advance();
      for (int k = 0; k < 4; k++) begin
         settle();
         expect_arb("t4_f0", 2'b01, 1'b1, 1'b0);
         expect_out("t4_f0", k != 0, prev);
         prev = 8'(8'h24 + k);
         advance();
      end
      for (int j = 0; j < 6; j++) begin
         settle();
         expect_arb("t4_f1", 2'b10, 1'b0, 1'b1);
         expect_out("t4_f1", 1'b1, prev);
         prev = 8'(8'hC2 + j);
         advance();
      end
      settle();
      expect_arb("t4_tail", 2'b10, 1'b0, 1'b0);
      expect_out("t4_tail", 1'b1, 8'hC7);
      advance();
      settle();
      expect_arb("t4_end", 2'b00, 1'b0, 1'b0);
      advance();
`else
      // strict priority: FIFO0 words preempt a FIFO1 stream
      for (int i = 0; i < 2; i++) begin
         settle();
         check("rst_pop0", 8'(bus.pop_0), 8'h00);
         check("rst_pop1", 8'(bus.pop_1), 8'h00);
         advance();
      end
      reset = 1'b1;
      for (int i = 0; i < 12; i++) q1.push_back(8'(8'h50 + i));
      settle();
      expect_arb("s_idle", 2'b00, 1'b0, 1'b0);
      expect_out("s_idle", 1'b0, 8'h00);
      advance();
      settle();
      expect_arb("s_p50", 2'b10, 1'b0, 1'b1);
      advance();
      settle();
      expect_arb("s_p51", 2'b10, 1'b0, 1'b1);
      expect_out("s_p51", 1'b1, 8'h50);
      advance();
      for (int i = 0; i < 3; i++) q0.push_back(8'(8'h30 + i));
      settle();
      expect_arb("s_p52", 2'b10, 1'b0, 1'b1);
      expect_out("s_p52", 1'b1, 8'h51);
      advance();
      prev = 8'h52;
      for (int k = 0; k < 3; k++) begin
         settle();
         expect_arb("s_f0", 2'b01, 1'b1, 1'b0);
         expect_out("s_f0", 1'b1, prev);
         prev = 8'(8'h30 + k);
         advance();
      end
      settle();
      expect_arb("s_drain", 2'b01, 1'b0, 1'b0);
      expect_out("s_drain", 1'b1, 8'h32);
      advance();
      settle();
      expect_arb("s_back", 2'b10, 1'b0, 1'b1);
      expect_out("s_back", 1'b0, 8'h00);
      advance();
      settle();
      expect_out("s_back1", 1'b1, 8'h53);
      advance();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_arb_2x1.md
FIFO_ARB_2X1 -- requirements
Module: fifo_arb_2x1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of both FIFO data inputs and data_out.
REQ-002 SHALL have parameter MAX_BURST, default 4, max words popped from one FIFO per grant while the other FIFO is non-empty (legal 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports empty_0 / empty_1  input  1 each  empty flags of the two upstream show-ahead FIFOs.
REQ-006 SHALL have ports data_in0 / data_in1  input  DATA_WIDTH each  FIFO head words, valid whenever the matching empty_x is 0.
REQ-007 SHALL have port almost_full  input  1  downstream backpressure; 1 blocks all pops.
REQ-008 SHALL have ports pop_0 / pop_1  output  1 each  combinational read strobes to the FIFOs.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  registered forwarded word.
REQ-010 SHALL have port valid_out  output  1  registered qualifier of data_out.
REQ-011 SHALL have port grant  output  2  registered one-hot owner (01 = FIFO0, 10 = FIFO1, 00 = idle).

Function
REQ-012 SHALL implement FSM states IDLE, GRANT0, GRANT1; grant SHALL decode the state register directly.
REQ-013 SHALL drive pop_x = reset & (state==GRANTx) & !empty_x & !almost_full; at most one pop SHALL be high per cycle.
REQ-014 SHALL, on the edge ending a cycle with pop_x=1, load data_out <= data_inx and valid_out <= 1 (latency 1 cycle); otherwise valid_out <= 0 and data_out holds.
REQ-015 SHALL keep a 1-bit last_served pointer, updated to x on every pop_x.
REQ-016 IDLE: both non-empty -> grant the FIFO opposite last_served; exactly one non-empty -> grant that FIFO; neither -> stay IDLE.
REQ-017 GRANTx: burst_cnt (4 bits) SHALL increment on each pop_x and reset to 0 on every state change.
REQ-018 GRANTx with empty_x=1 (no pop): go to GRANTy if empty_y=0, else IDLE.
REQ-019 GRANTx, pop_x=1, burst_cnt==MAX_BURST-1: go to GRANTy if empty_y=0; else stay GRANTx with burst_cnt <= 0.
REQ-020 GRANTx with almost_full=1: state and burst_cnt SHALL hold; empty flags ignored for transitions that cycle.
REQ-021 One-cycle bubble after a FIFO empties or grant switches is permitted; no word SHALL be duplicated or dropped.

Reset
REQ-022 SHALL, on a clock edge with reset=0, set state=IDLE, burst_cnt=0, last_served=1 (FIFO0 served first), data_out=0, valid_out=0, grant=00.
REQ-023 SHALL force pop_0=pop_1=0 in any cycle with reset=0, including mid-burst; no word SHALL be consumed during reset.

Configuration
REQ-024 With macro ARB_STRICT_PRIO_EN defined, FIFO0 SHALL have strict priority: MAX_BURST is ignored in GRANT0; in GRANT1 after any pop_1, if empty_0=0 the next state SHALL be GRANT0; in IDLE FIFO0 wins whenever non-empty.
REQ-025 Without ARB_STRICT_PRIO_EN, round-robin with MAX_BURST per REQ-016..REQ-019 SHALL apply.

Verification
REQ-026 Reset with both FIFOs holding 8 words, then release, almost_full=0 -> pops 0,0,0,0 (FIFO0), then 4 from FIFO1, alternating in bursts of 4; valid_out one cycle after each pop.
REQ-027 Only FIFO1 holds 10 words -> 10 consecutive pop_1 (burst counter wraps, no switch), data_out matches FIFO1 order, then IDLE.
REQ-028 Mid-burst (2 words popped from FIFO0) assert almost_full for 5 cycles -> no pops, grant holds 01, valid_out=0; on release 2 more FIFO0 words then switch.
REQ-029 Assert reset for 1 cycle during GRANT1 burst -> pops 0 that cycle, valid_out=0, grant=00 next cycle, next grant goes to FIFO0 if non-empty.
REQ-030 ARB_STRICT_PRIO_EN, FIFO1 streaming, FIFO0 receives 3 words -> after current pop_1, grant=01, 3 FIFO0 pops, then back to FIFO1.
